// File: rtl/rifl_tx_retrans_buf.sv
// Transmit-side go-back-N replay buffer: holds issued frames until acknowledged,
// replays from the oldest unacknowledged frame on request, and honours pause.
module rifl_tx_retrans_buf #(
    parameter int DWIDTH         = 240,
    parameter int FRAME_ID_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DWIDTH-1:0]         s_data,
    input  logic                      s_vld,
    output logic                      s_rdy,
    output logic [DWIDTH-1:0]         m_data,
    output logic [FRAME_ID_WIDTH-1:0] m_id,
    output logic                      m_vld,
    input  logic                      m_rdy,
    input  logic                      ack_vld,
    input  logic [FRAME_ID_WIDTH-1:0] ack_id,
    input  logic                      pause_req,
    input  logic                      retrans_req,
    input  logic                      link_up,
    output logic [15:0]               retrans_cnt
);

    localparam int DEPTH = 1 << FRAME_ID_WIDTH;
    localparam int PTR_W = FRAME_ID_WIDTH + 1;

    logic [DWIDTH-1:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_ack_ptr;
    logic [PTR_W-1:0]          r_send_ptr;
    logic [DWIDTH-1:0]         r_m_data;
    logic [FRAME_ID_WIDTH-1:0] r_m_id;
    logic                      r_m_vld;
    logic [15:0]               r_retrans_cnt;

    logic [PTR_W-1:0]          w_occ;
    logic                      w_full;
    logic                      w_wr;
    logic [PTR_W-1:0]          w_inflight;
    logic [FRAME_ID_WIDTH-1:0] w_ack_d;
    logic                      w_ack_ok;
    logic [PTR_W-1:0]          w_ack_nxt;
    logic                      w_load;

    // Occupancy, write handshake and ack window evaluation from registered pointers
    always_comb begin
        w_occ      = r_wr_ptr - r_ack_ptr;
        w_full     = (w_occ == PTR_W'(DEPTH));
        s_rdy      = ~rst & ~w_full;
        w_wr       = s_vld & s_rdy;
        w_inflight = r_send_ptr - r_ack_ptr;
        w_ack_d    = ack_id - r_ack_ptr[FRAME_ID_WIDTH-1:0] + FRAME_ID_WIDTH'(1);
        // d==0 and anything beyond the issued window are stale/duplicate/bogus acks
        if (ack_vld && (w_ack_d != '0) && ({1'b0, w_ack_d} <= w_inflight)) begin
            w_ack_ok = 1'b1;
        end else begin
            w_ack_ok = 1'b0;
        end
        if (w_ack_ok) begin
            w_ack_nxt = r_ack_ptr + {1'b0, w_ack_d};
        end else begin
            w_ack_nxt = r_ack_ptr;
        end
        w_load = (~r_m_vld | m_rdy) & (r_send_ptr != r_wr_ptr) & ~pause_req
                 & link_up & ~retrans_req;
    end

    // Frame storage; reads happen only through the output register load
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[FRAME_ID_WIDTH-1:0]] <= s_data;
        end
    end

    // Pointer, output register and retransmit counter update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_ack_ptr     <= '0;
            r_send_ptr    <= '0;
            r_m_data      <= '0;
            r_m_id        <= '0;
            r_m_vld       <= 1'b0;
            r_retrans_cnt <= 16'h0000;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_ack_ptr <= w_ack_nxt;

            if (!link_up) begin
                r_send_ptr <= w_ack_nxt;
                r_m_vld    <= 1'b0;
            end else if (retrans_req) begin
                if (r_retrans_cnt != 16'hFFFF) begin
                    r_retrans_cnt <= r_retrans_cnt + 16'h0001;
                end
                // Nothing outstanding: count the request but keep the output as is
                if (w_ack_nxt != r_send_ptr) begin
                    r_send_ptr <= w_ack_nxt;
                    r_m_vld    <= 1'b0;
                end else if (m_rdy) begin
                    r_m_vld <= 1'b0;
                end
            end else if (w_load) begin
                r_m_data   <= r_mem[r_send_ptr[FRAME_ID_WIDTH-1:0]];
                r_m_id     <= r_send_ptr[FRAME_ID_WIDTH-1:0];
                r_m_vld    <= 1'b1;
                r_send_ptr <= r_send_ptr + PTR_W'(1);
            end else if (m_rdy) begin
                r_m_vld <= 1'b0;
            end
        end
    end

    assign m_data      = r_m_data;
    assign m_id        = r_m_id;
    assign m_vld       = r_m_vld;
    assign retrans_cnt = r_retrans_cnt;

endmodule

// File: tb/tb_rifl_tx_retrans_buf.sv
// Scoreboard bench for rifl_tx_retrans_buf with DEPTH=8, DWIDTH=16.
module tb_rifl_tx_retrans_buf;

    localparam int DW  = 16;
    localparam int FIW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  s_data;
    logic           s_vld;
    logic           s_rdy;
    logic [DW-1:0]  m_data;
    logic [FIW-1:0] m_id;
    logic           m_vld;
    logic           m_rdy;
    logic           ack_vld;
    logic [FIW-1:0] ack_id;
    logic           pause_req;
    logic           retrans_req;
    logic           link_up;
    logic [15:0]    retrans_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [FIW+DW-1:0] q[$];
    logic              xfer_pending = 1'b0;
    logic [FIW-1:0]    last_id = '0;

    rifl_tx_retrans_buf #(.DWIDTH(DW), .FRAME_ID_WIDTH(FIW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
        .m_data(m_data), .m_id(m_id), .m_vld(m_vld), .m_rdy(m_rdy),
        .ack_vld(ack_vld), .ack_id(ack_id), .pause_req(pause_req),
        .retrans_req(retrans_req), .link_up(link_up), .retrans_cnt(retrans_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so at negedge a valid&ready pair is a transfer at the next edge
    always @(negedge clk) begin
        if (m_vld === 1'b1 && m_rdy === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame: got id=%0d data=%h, expected none", m_id, m_data);
            end else begin
                logic [FIW+DW-1:0] exp_v;
                exp_v = q.pop_front();
                if ({m_id, m_data} !== exp_v) begin
                    n_fail++;
                    $display("FAIL frame_order: got id=%0d data=%h, expected id=%0d data=%h",
                             m_id, m_data, exp_v[FIW+DW-1:DW], exp_v[DW-1:0]);
                end
            end
            xfer_pending = 1'b1;
            last_id      = m_id;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [DW-1:0] d);
        logic [FIW-1:0] id;
        id = FIW'(idx % 8);
        q.push_back({id, d});
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 60; k++) begin
            if (q.size() == 0) break;
            cyc();
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d frames still pending, expected 0", nm, q.size());
        end
    endtask

    task automatic test_reset();
        s_vld = 1'b0; s_data = '0; m_rdy = 1'b0; ack_vld = 1'b0; ack_id = '0;
        pause_req = 1'b0; retrans_req = 1'b0; link_up = 1'b1;
        rst = 1'b1;
        cyc(); cyc(); cyc();
        n_tests++;
        if (s_rdy !== 1'b0 || m_vld !== 1'b0 || m_id !== '0 || m_data !== '0 || retrans_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: s_rdy=%b m_vld=%b m_id=%0d m_data=%h cnt=%0d, expected 0 0 0 0000 0",
                     s_rdy, m_vld, m_id, m_data, retrans_cnt);
        end
        q.delete();
        xfer_pending = 1'b0;
        rst = 1'b0;
        cyc();
        n_tests++;
        if (s_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: s_rdy=%b, expected 1", s_rdy);
        end
    endtask

    task automatic test_basic();
        m_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_vld = 1'b1; s_data = DW'(16'h0100 + i);
            push_exp(i, s_data);
            cyc();
            if (i == 0) begin
                n_tests++;
                if (m_vld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_latency1: m_vld=%b one cycle after write, expected 0", m_vld);
                end
            end else if (i == 1) begin
                n_tests++;
                if (m_vld !== 1'b1 || m_id !== 3'd0) begin
                    n_fail++;
                    $display("FAIL basic_latency2: m_vld=%b m_id=%0d, expected 1 0", m_vld, m_id);
                end
            end
        end
        s_vld = 1'b0;
        wait_drain("basic");
    endtask

    task automatic test_full_ack();
        m_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_vld = 1'b1; s_data = DW'(16'h0200 + i);
            push_exp(i, s_data);
            cyc();
        end
        n_tests++;
        if (s_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_9th: s_rdy=%b, expected 0", s_rdy);
        end
        s_vld = 1'b0;
        wait_drain("full");
        ack_vld = 1'b1; ack_id = 3'd2;
        cyc();
        ack_vld = 1'b1; ack_id = 3'd1;
        n_tests++;
        if (s_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_frees: s_rdy=%b, expected 1", s_rdy);
        end
        cyc();
        ack_vld = 1'b0;
        // Occupancy 5 means exactly three more writes fit
        for (int i = 8; i < 11; i++) begin
            n_tests++;
            if (s_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL occupancy_room%0d: s_rdy=%b, expected 1", i, s_rdy);
            end
            s_vld = 1'b1; s_data = DW'(16'h0200 + i);
            push_exp(i, s_data);
            cyc();
        end
        s_vld = 1'b0;
        n_tests++;
        if (s_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_ack_ignored: s_rdy=%b, expected 0", s_rdy);
        end
        wait_drain("full2");
    endtask

    task automatic test_retransmit();
        m_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_vld = 1'b1; s_data = DW'(16'h0300 + i);
            push_exp(i, s_data);
            cyc();
        end
        s_vld = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (q.size() <= 1) break;
            cyc();
        end
        n_tests++;
        if (m_vld !== 1'b1 || m_id !== 3'd5 || q.size() != 1) begin
            n_fail++;
            $display("FAIL retrans_hold: m_vld=%b m_id=%0d pending=%0d, expected 1 5 1", m_vld, m_id, q.size());
        end
        m_rdy = 1'b0;
        ack_vld = 1'b1; ack_id = 3'd1;
        cyc();
        ack_vld = 1'b0; retrans_req = 1'b1;
        cyc();
        retrans_req = 1'b0;
        n_tests++;
        if (m_vld !== 1'b0 || retrans_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL retrans_flush: m_vld=%b cnt=%0d, expected 0 1", m_vld, retrans_cnt);
        end
        q.delete();
        for (int i = 2; i < 6; i++) push_exp(i, DW'(16'h0300 + i));
        m_rdy = 1'b1;
        wait_drain("retrans");
    endtask

    task automatic test_pause();
        m_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_vld = 1'b1; s_data = DW'(16'h0700 + i);
            push_exp(i, s_data);
            cyc();
        end
        s_vld = 1'b0;
        cyc();
        pause_req = 1'b1;
        cyc(); cyc(); cyc();
        n_tests++;
        if (m_vld !== 1'b1 || m_id !== 3'd0 || m_data !== 16'h0700) begin
            n_fail++;
            $display("FAIL pause_hold: m_vld=%b m_id=%0d m_data=%h, expected 1 0 0700", m_vld, m_id, m_data);
        end
        m_rdy = 1'b1;
        cyc(); cyc(); cyc();
        n_tests++;
        if (m_vld !== 1'b0 || q.size() != 2) begin
            n_fail++;
            $display("FAIL pause_block: m_vld=%b pending=%0d, expected 0 2", m_vld, q.size());
        end
        pause_req = 1'b0;
        wait_drain("pause");
    endtask

    task automatic test_link_down();
        m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_vld = 1'b1; s_data = DW'(16'h0500 + i);
            push_exp(i, s_data);
            cyc();
        end
        s_vld = 1'b0;
        wait_drain("link_pre");
        ack_vld = 1'b1; ack_id = 3'd0;
        cyc();
        ack_vld = 1'b0;
        link_up = 1'b0;
        s_vld = 1'b1; s_data = 16'h0504;
        for (int k = 0; k < 5; k++) begin
            cyc();
            s_vld = 1'b0;
            n_tests++;
            if (m_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL link_down_idle%0d: m_vld=%b, expected 0", k, m_vld);
            end
        end
        for (int i = 1; i < 5; i++) push_exp(i, DW'(16'h0500 + i));
        link_up = 1'b1;
        wait_drain("link");
        n_tests++;
        if (retrans_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL link_cnt: retrans_cnt=%0d, expected 0", retrans_cnt);
        end
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        m_rdy = 1'b1;
        xfer_pending = 1'b0;
        for (int k = 0; k < 120; k++) begin
            ack_vld = xfer_pending; ack_id = last_id;
            xfer_pending = 1'b0;
            if (n < 20 && s_rdy === 1'b1) begin
                s_vld = 1'b1; s_data = DW'(16'h0400 + n);
                push_exp(n, s_data);
                n++;
            end else begin
                s_vld = 1'b0;
            end
            cyc();
            if (n == 20 && q.size() == 0 && !xfer_pending) break;
        end
        ack_vld = 1'b0; s_vld = 1'b0;
        n_tests++;
        if (n != 20 || q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_stream: written=%0d pending=%0d, expected 20 0", n, q.size());
        end
        for (int i = 20; i < 24; i++) begin
            s_vld = 1'b1; s_data = DW'(16'h0400 + i);
            push_exp(i, s_data);
            cyc();
        end
        s_vld = 1'b0;
        wait_drain("wrap_tail");
        ack_vld = 1'b1; ack_id = 3'd5; retrans_req = 1'b1;
        cyc();
        ack_vld = 1'b0; retrans_req = 1'b0;
        n_tests++;
        if (m_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_retrans_flush: m_vld=%b, expected 0", m_vld);
        end
        push_exp(22, 16'h0416);
        push_exp(23, 16'h0417);
        wait_drain("wrap_replay");
        n_tests++;
        if (retrans_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL wrap_cnt: retrans_cnt=%0d, expected 1", retrans_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset();
        test_full_ack();
        test_reset();
        test_retransmit();
        test_reset();
        test_pause();
        test_reset();
        test_link_down();
        test_reset();
        test_wrap();
        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
